// File: rtl/exu_lsu_pkg.sv
// ----------------------------------------------------------------------------
// exu_lsu_pkg
// Shared definitions for the load/store stage:
//   - lsu_state_e : FSM encoding (IDLE / REQ / RESP)
//   - RD_*        : bit positions inside the 4-bit load-type field
//   - store_be_legal() : the set of byte-enable patterns a store may use
// ----------------------------------------------------------------------------
package exu_lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_e;

    localparam int RD_B = 0;
    localparam int RD_H = 1;
    localparam int RD_W = 2;
    localparam int RD_U = 3;

    // Naturally aligned byte, half and word lanes only.
    function automatic logic store_be_legal(input logic [3:0] be);
        case (be)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/exu_lsu_ldext.sv
// ----------------------------------------------------------------------------
// exu_lsu_ldext
// Purely combinational load-data aligner and extender.
//   i_addr_lo : byte offset of the access (addr[1:0])
//   i_rdtype  : load type {unsigned, word, half, byte}
//   i_rdata   : raw 32-bit bus read data
//   o_data    : lane-extracted, sign/zero-extended result
// ----------------------------------------------------------------------------
module exu_lsu_ldext
    import exu_lsu_pkg::*;
(
    input  logic [1:0]  i_addr_lo,
    input  logic [3:0]  i_rdtype,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_is_word;
    logic        w_sext;

    always_comb begin
        case (i_addr_lo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

        // A type field with neither byte nor half set is treated as a word.
        w_is_word = i_rdtype[RD_W] | ~(i_rdtype[RD_B] | i_rdtype[RD_H]);
        w_sext    = ~i_rdtype[RD_U];

        if (w_is_word) begin
            o_data = i_rdata;
        end else if (i_rdtype[RD_H]) begin
            o_data = {{16{w_half[15] & w_sext}}, w_half};
        end else begin
            o_data = {{24{w_byte[7] & w_sext}}, w_byte};
        end
    end

endmodule

// File: rtl/exu_lsu.sv
// ----------------------------------------------------------------------------
// exu_lsu
// Load/store stage following the execute stage. Accepts one instruction at a
// time, runs the data-bus request/grant/response handshake, aligns/extends
// load data and issues a single-cycle registered writeback.
//   clk, rst_n          : clock, synchronous active-low reset
//   i_valid / o_ready   : upstream handshake (o_ready only in IDLE)
//   i_result            : writeback data for non-memory instructions
//   i_rd_wen/i_rd_addr  : destination register
//   i_mem_wen/i_mem_ren : store / load request (store wins if both)
//   i_mem_addr/_wdata   : effective address, lane-positioned store data
//   i_data_be           : store byte enables
//   i_mem_rdtype        : load type {U, W, H, B}
//   o_dbus_*            : data-bus request, held stable until i_dbus_gnt
//   i_dbus_rvalid/rdata : read response
//   o_wb_*              : register-file write, o_wb_valid pulses once
//   o_misalign          : qualifies o_wb_valid for a suppressed access
// ----------------------------------------------------------------------------
module exu_lsu
    import exu_lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [31:0] i_result,
    input  logic        i_rd_wen,
    input  logic [4:0]  i_rd_addr,
    input  logic        i_mem_wen,
    input  logic        i_mem_ren,
    input  logic [31:0] i_mem_addr,
    input  logic [31:0] i_mem_wdata,
    input  logic [3:0]  i_data_be,
    input  logic [3:0]  i_mem_rdtype,
    output logic        o_dbus_req,
    output logic        o_dbus_we,
    output logic [31:0] o_dbus_addr,
    output logic [3:0]  o_dbus_be,
    output logic [31:0] o_dbus_wdata,
    input  logic        i_dbus_gnt,
    input  logic        i_dbus_rvalid,
    input  logic [31:0] i_dbus_rdata,
    output logic        o_wb_valid,
    output logic        o_wb_rd_wen,
    output logic [4:0]  o_wb_rd_addr,
    output logic [31:0] o_wb_rd_data,
    output logic        o_misalign
);

    lsu_state_e  r_state;
    lsu_state_e  w_state_nxt;

    // Latched request, held while the bus transaction is outstanding
    logic        r_is_store;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic [3:0]  r_rdtype;
    logic        r_rd_wen;
    logic [4:0]  r_rd_addr;

    // Writeback register
    logic        r_wb_valid;
    logic        r_wb_rd_wen;
    logic [4:0]  r_wb_rd_addr;
    logic [31:0] r_wb_rd_data;
    logic        r_misalign;

    logic        w_accept;
    logic        w_is_store;
    logic        w_is_load;
    logic        w_ld_mis;
    logic        w_st_mis;
    logic        w_mis;
    logic [31:0] w_ld_data;

    assign w_accept   = i_valid && (r_state == ST_IDLE);
    assign w_is_store = i_mem_wen;
    assign w_is_load  = i_mem_ren && !i_mem_wen;
    assign w_ld_mis   = (i_mem_rdtype[RD_H] && i_mem_addr[0]) ||
                        (i_mem_rdtype[RD_W] && (i_mem_addr[1:0] != 2'd0));
    assign w_st_mis   = !store_be_legal(i_data_be);
    assign w_mis      = (w_is_load && w_ld_mis) || (w_is_store && w_st_mis);

    exu_lsu_ldext u_ldext (
        .i_addr_lo (r_addr[1:0]),
        .i_rdtype  (r_rdtype),
        .i_rdata   (i_dbus_rdata),
        .o_data    (w_ld_data)
    );

    // ---- FSM state register ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---- FSM next state and state-decoded outputs ----
    always_comb begin
        w_state_nxt = r_state;
        o_ready     = 1'b0;
        o_dbus_req  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_ready = 1'b1;
                if (w_accept && (w_is_store || w_is_load) && !w_mis) begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                o_dbus_req = 1'b1;
                if (i_dbus_gnt) begin
                    w_state_nxt = r_is_store ? ST_IDLE : ST_RESP;
                end
            end
            ST_RESP: begin
                if (i_dbus_rvalid) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ---- Request latch and writeback register ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_is_store   <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_be         <= '0;
            r_rdtype     <= '0;
            r_rd_wen     <= 1'b0;
            r_rd_addr    <= '0;
            r_wb_valid   <= 1'b0;
            r_wb_rd_wen  <= 1'b0;
            r_wb_rd_addr <= '0;
            r_wb_rd_data <= '0;
            r_misalign   <= 1'b0;
        end else begin
            r_wb_valid  <= 1'b0;
            r_wb_rd_wen <= 1'b0;
            r_misalign  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_mis) begin
                            // Suppressed access retires at once without a write.
                            r_wb_valid   <= 1'b1;
                            r_misalign   <= 1'b1;
                            r_wb_rd_addr <= i_rd_addr;
                            r_wb_rd_data <= i_result;
                        end else if (w_is_store || w_is_load) begin
                            r_is_store <= w_is_store;
                            r_addr     <= i_mem_addr;
                            r_wdata    <= i_mem_wdata;
                            r_be       <= w_is_store ? i_data_be : 4'b1111;
                            r_rdtype   <= i_mem_rdtype;
                            r_rd_wen   <= i_rd_wen;
                            r_rd_addr  <= i_rd_addr;
                        end else begin
                            r_wb_valid   <= 1'b1;
                            r_wb_rd_wen  <= i_rd_wen;
                            r_wb_rd_addr <= i_rd_addr;
                            r_wb_rd_data <= i_result;
                        end
                    end
                end
                ST_REQ: begin
                    if (i_dbus_gnt && r_is_store) begin
                        r_wb_valid   <= 1'b1;
                        r_wb_rd_addr <= r_rd_addr;
                    end
                end
                ST_RESP: begin
                    if (i_dbus_rvalid) begin
                        r_wb_valid   <= 1'b1;
                        r_wb_rd_wen  <= r_rd_wen;
                        r_wb_rd_addr <= r_rd_addr;
                        r_wb_rd_data <= w_ld_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_dbus_we    = r_is_store;
    assign o_dbus_addr  = r_addr;
    assign o_dbus_be    = r_be;
    assign o_dbus_wdata = r_wdata;
    assign o_wb_valid   = r_wb_valid;
    assign o_wb_rd_wen  = r_wb_rd_wen;
    assign o_wb_rd_addr = r_wb_rd_addr;
    assign o_wb_rd_data = r_wb_rd_data;
    assign o_misalign   = r_misalign;

endmodule

// File: tb/tb_exu_lsu.sv
module tb_exu_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_result;
    logic        i_rd_wen;
    logic [4:0]  i_rd_addr;
    logic        i_mem_wen;
    logic        i_mem_ren;
    logic [31:0] i_mem_addr;
    logic [31:0] i_mem_wdata;
    logic [3:0]  i_data_be;
    logic [3:0]  i_mem_rdtype;
    logic        o_dbus_req;
    logic        o_dbus_we;
    logic [31:0] o_dbus_addr;
    logic [3:0]  o_dbus_be;
    logic [31:0] o_dbus_wdata;
    logic        i_dbus_gnt;
    logic        i_dbus_rvalid;
    logic [31:0] i_dbus_rdata;
    logic        o_wb_valid;
    logic        o_wb_rd_wen;
    logic [4:0]  o_wb_rd_addr;
    logic [31:0] o_wb_rd_data;
    logic        o_misalign;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int          cyc;
        logic        rd_wen;
        logic [4:0]  rd_addr;
        logic [31:0] data;
        logic        chk_data;
        logic        mis;
    } exp_t;

    exp_t sbq[$];
    exp_t e;

    exu_lsu dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_result      (i_result),
        .i_rd_wen      (i_rd_wen),
        .i_rd_addr     (i_rd_addr),
        .i_mem_wen     (i_mem_wen),
        .i_mem_ren     (i_mem_ren),
        .i_mem_addr    (i_mem_addr),
        .i_mem_wdata   (i_mem_wdata),
        .i_data_be     (i_data_be),
        .i_mem_rdtype  (i_mem_rdtype),
        .o_dbus_req    (o_dbus_req),
        .o_dbus_we     (o_dbus_we),
        .o_dbus_addr   (o_dbus_addr),
        .o_dbus_be     (o_dbus_be),
        .o_dbus_wdata  (o_dbus_wdata),
        .i_dbus_gnt    (i_dbus_gnt),
        .i_dbus_rvalid (i_dbus_rvalid),
        .i_dbus_rdata  (i_dbus_rdata),
        .o_wb_valid    (o_wb_valid),
        .o_wb_rd_wen   (o_wb_rd_wen),
        .o_wb_rd_addr  (o_wb_rd_addr),
        .o_wb_rd_data  (o_wb_rd_data),
        .o_misalign    (o_misalign)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Writeback monitor: every pulse must match the oldest expected retire.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && o_wb_valid === 1'b1) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_wb: cyc=%0d rd=%0d data=%h", cyc, o_wb_rd_addr, o_wb_rd_data);
            end else begin
                e = sbq.pop_front();
                if (cyc !== e.cyc) begin
                    errors++;
                    $display("FAIL wb_latency: got cycle %0d want %0d", cyc, e.cyc);
                end
                checks++;
                if (o_wb_rd_wen !== e.rd_wen || o_wb_rd_addr !== e.rd_addr) begin
                    errors++;
                    $display("FAIL wb_rd: got wen=%b rd=%0d want wen=%b rd=%0d",
                             o_wb_rd_wen, o_wb_rd_addr, e.rd_wen, e.rd_addr);
                end
                checks++;
                if (o_misalign !== e.mis) begin
                    errors++;
                    $display("FAIL wb_misalign: got %b want %b", o_misalign, e.mis);
                end
                if (e.chk_data) begin
                    checks++;
                    if (o_wb_rd_data !== e.data) begin
                        errors++;
                        $display("FAIL wb_data: got %h want %h", o_wb_rd_data, e.data);
                    end
                end
            end
        end
    end

    task automatic idle_inputs;
        i_valid = 0; i_result = '0; i_rd_wen = 0; i_rd_addr = '0;
        i_mem_wen = 0; i_mem_ren = 0; i_mem_addr = '0; i_mem_wdata = '0;
        i_data_be = '0; i_mem_rdtype = '0;
        i_dbus_gnt = 0; i_dbus_rvalid = 0; i_dbus_rdata = '0;
    endtask

    task automatic test_reset;
        rst_n = 0;
        idle_inputs();
        repeat (3) @(negedge clk);
        checks++;
        if (o_dbus_req !== 0 || o_dbus_we !== 0 || o_dbus_addr !== 0 ||
            o_dbus_be !== 0 || o_dbus_wdata !== 0) begin
            errors++;
            $display("FAIL reset_dbus: req=%b we=%b addr=%h be=%h wdata=%h",
                     o_dbus_req, o_dbus_we, o_dbus_addr, o_dbus_be, o_dbus_wdata);
        end
        checks++;
        if (o_wb_valid !== 0 || o_wb_rd_wen !== 0 || o_wb_rd_addr !== 0 ||
            o_wb_rd_data !== 0 || o_misalign !== 0) begin
            errors++;
            $display("FAIL reset_wb: valid=%b wen=%b rd=%0d data=%h mis=%b want all 0",
                     o_wb_valid, o_wb_rd_wen, o_wb_rd_addr, o_wb_rd_data, o_misalign);
        end
        rst_n = 1;
        @(negedge clk);
        checks++;
        if (o_ready !== 1) begin
            errors++;
            $display("FAIL reset_ready: got %b want 1", o_ready);
        end
    endtask

    task automatic test_back_to_back;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (o_ready !== 1) begin
                errors++;
                $display("FAIL b2b_ready: got %b want 1 (k=%0d)", o_ready, k);
            end
            i_valid = 1; i_rd_wen = 1; i_rd_addr = 5'(k + 1);
            i_result = 32'h11 * (k + 1);
            sbq.push_back('{cyc + 1, 1'b1, 5'(k + 1), 32'h11 * (k + 1), 1'b1, 1'b0});
            @(negedge clk);
            checks++;
            if (o_dbus_req !== 0) begin
                errors++;
                $display("FAIL b2b_no_bus: req=%b want 0", o_dbus_req);
            end
        end
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic do_load(input logic [31:0] addr, input logic [3:0] rt,
                           input logic [31:0] rdata, input logic [4:0] rd,
                           input int gw, input int rw, input logic [31:0] exp_data);
        checks++;
        if (o_ready !== 1) begin
            errors++;
            $display("FAIL load_ready: got %b want 1", o_ready);
        end
        i_valid = 1; i_mem_ren = 1; i_mem_addr = addr; i_mem_rdtype = rt;
        i_rd_wen = 1; i_rd_addr = rd;
        @(negedge clk);
        idle_inputs();
        checks++;
        if (o_dbus_req !== 1 || o_dbus_we !== 0 || o_dbus_addr !== addr || o_dbus_be !== 4'hF) begin
            errors++;
            $display("FAIL load_req: req=%b we=%b addr=%h be=%h want 1 0 %h f",
                     o_dbus_req, o_dbus_we, o_dbus_addr, o_dbus_be, addr);
        end
        repeat (gw) @(negedge clk);
        i_dbus_gnt = 1;
        @(negedge clk);
        i_dbus_gnt = 0;
        checks++;
        if (o_dbus_req !== 0 || o_ready !== 0) begin
            errors++;
            $display("FAIL load_resp_state: req=%b ready=%b want 0 0", o_dbus_req, o_ready);
        end
        repeat (rw) @(negedge clk);
        i_dbus_rvalid = 1; i_dbus_rdata = rdata;
        sbq.push_back('{cyc + 1, 1'b1, rd, exp_data, 1'b1, 1'b0});
        @(negedge clk);
        i_dbus_rvalid = 0; i_dbus_rdata = '0;
        @(negedge clk);
    endtask

    task automatic test_loads;
        do_load(32'h1003, 4'b0001, 32'h80FF_0000, 5'd4, 1, 2, 32'hFFFF_FF80);
        do_load(32'h1003, 4'b1001, 32'h80FF_0000, 5'd5, 1, 2, 32'h0000_0080);
        do_load(32'h2002, 4'b0010, 32'h8001_1234, 5'd6, 0, 0, 32'hFFFF_8001);
        do_load(32'h2000, 4'b0100, 32'h8001_1234, 5'd0, 0, 1, 32'h8001_1234);
        do_load(32'h2001, 4'b0001, 32'h8001_1234, 5'd8, 2, 0, 32'h0000_0012);
    endtask

    task automatic test_store_stable;
        i_valid = 1; i_mem_wen = 1; i_mem_addr = 32'h3000; i_data_be = 4'hF;
        i_mem_wdata = 32'hDEAD_BEEF; i_rd_wen = 1; i_rd_addr = 5'd9;
        @(negedge clk);
        idle_inputs();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (o_dbus_req !== 1 || o_dbus_we !== 1 || o_dbus_addr !== 32'h3000 ||
                o_dbus_be !== 4'hF || o_dbus_wdata !== 32'hDEAD_BEEF) begin
                errors++;
                $display("FAIL store_stable: k=%0d req=%b we=%b addr=%h be=%h wdata=%h",
                         k, o_dbus_req, o_dbus_we, o_dbus_addr, o_dbus_be, o_dbus_wdata);
            end
            @(negedge clk);
        end
        i_dbus_gnt = 1;
        sbq.push_back('{cyc + 1, 1'b0, 5'd9, 32'h0, 1'b0, 1'b0});
        @(negedge clk);
        i_dbus_gnt = 0;
        checks++;
        if (o_dbus_req !== 0 || o_ready !== 1) begin
            errors++;
            $display("FAIL store_done: req=%b ready=%b want 0 1", o_dbus_req, o_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_misalign;
        // LW at 0x4002
        i_valid = 1; i_mem_ren = 1; i_mem_addr = 32'h4002; i_mem_rdtype = 4'b0100;
        i_rd_wen = 1; i_rd_addr = 5'd10;
        sbq.push_back('{cyc + 1, 1'b0, 5'd10, 32'h0, 1'b0, 1'b1});
        @(negedge clk);
        idle_inputs();
        checks++;
        if (o_dbus_req !== 0 || o_ready !== 1) begin
            errors++;
            $display("FAIL mis_lw_nobus: req=%b ready=%b want 0 1", o_dbus_req, o_ready);
        end
        // SH with be 0110
        i_valid = 1; i_mem_wen = 1; i_mem_addr = 32'h4001; i_data_be = 4'b0110;
        i_mem_wdata = 32'h00AB_CD00; i_rd_wen = 1; i_rd_addr = 5'd11;
        sbq.push_back('{cyc + 1, 1'b0, 5'd11, 32'h0, 1'b0, 1'b1});
        @(negedge clk);
        idle_inputs();
        checks++;
        if (o_dbus_req !== 0 || o_ready !== 1) begin
            errors++;
            $display("FAIL mis_sh_nobus: req=%b ready=%b want 0 1", o_dbus_req, o_ready);
        end
        @(negedge clk);
        checks++;
        if (o_misalign !== 0 || o_dbus_req !== 0) begin
            errors++;
            $display("FAIL mis_after: misalign=%b req=%b want 0 0", o_misalign, o_dbus_req);
        end
    endtask

    task automatic test_reset_abort;
        i_valid = 1; i_mem_ren = 1; i_mem_addr = 32'h5000; i_mem_rdtype = 4'b0100;
        i_rd_wen = 1; i_rd_addr = 5'd7;
        @(negedge clk);
        idle_inputs();
        i_dbus_gnt = 1;
        @(negedge clk);
        i_dbus_gnt = 0;
        checks++;
        if (o_ready !== 0) begin
            errors++;
            $display("FAIL abort_in_resp: ready=%b want 0", o_ready);
        end
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        checks++;
        if (o_ready !== 1 || o_dbus_req !== 0 || o_wb_valid !== 0) begin
            errors++;
            $display("FAIL abort_idle: ready=%b req=%b wb=%b want 1 0 0",
                     o_ready, o_dbus_req, o_wb_valid);
        end
        i_dbus_rvalid = 1; i_dbus_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        i_dbus_rvalid = 0; i_dbus_rdata = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (o_ready !== 1) begin
            errors++;
            $display("FAIL abort_late_rvalid: ready=%b want 1", o_ready);
        end
        do_load(32'h5004, 4'b0100, 32'h1234_5678, 5'd7, 0, 0, 32'h1234_5678);
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_loads();
        test_store_stable();
        test_misalign();
        test_reset_abort();
        repeat (3) @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL missing_wb: %0d expected retires never seen, want 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
